// File: rtl/uart_tx_sched_if.sv
// Byte-source side of the shared UART transmitter: per-requester req/data in, grant/owner/line state out.
// The scheduler is the slave; the requesters (or a bench) drive the master side.
interface uart_tx_sched_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data;
    logic [NREQ-1:0]        gnt;
    logic [OW-1:0]          owner;
    logic                   busy;
    logic                   txd;

    modport master (output req, data, input gnt, owner, busy, txd);
    modport slave  (input req, data, output gnt, owner, busy, txd);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin shares one 8N1 UART line between NREQ byte sources, bit timing from rising edges of clk16.
// Outputs registered (gnt/busy/txd one sysclk after grant); requesters wait, holding req, until granted in IDLE.
module uart_tx_sched #(
    parameter int NREQ       = 2,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic           sysclk,
    input  logic           rst,
    input  logic           clk16,
    uart_tx_sched_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic              clk16_q;
    logic              tick;
    logic              bit_end;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [OW-1:0]     last_q, last_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              found;
    logic [OW-1:0]     pick;
    int                idx;

    assign tick    = clk16 & ~clk16_q;
    assign bit_end = tick && (tick_q == TW'(OVERSAMPLE - 1));

    // First pending requester after the last one served, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt_d   = '0;
        txd_d   = txd_q;
        busy_d  = busy_q;
        if (state_q != IDLE && tick)
            tick_d = bit_end ? '0 : tick_q + TW'(1);
        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (found) begin
                    shift_d     = bus.data[int'(pick)*DATA_W +: DATA_W];
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    last_d      = pick;
                    tick_d      = '0;
                    bit_d       = '0;
                    txd_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = STOP;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        // LSB always on the line: shift the next bit down.
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            clk16_q <= 1'b0;
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= OW'(NREQ - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            clk16_q <= clk16;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.txd   = txd_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: tick-domain UART receiver plus round-robin grant model, one task per scenario.
module tb_uart_tx_sched;
    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int OS   = 16;
    localparam int MIDB = OS / 2;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    logic clk16  = 1'b0;
    bit   stall  = 1'b0;
    int   ph     = 0;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit auto_drop = 1'b1;
    int m_last = NREQ - 1;

    logic [NREQ-1:0] g_vec[$];
    int              g_own[$];

    logic       c16_prev = 1'b0;
    logic       rx_rise;
    int         rx_st = 0;
    int         rx_n  = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;
    int         rx0 = 0;
    int         fe0 = 0;

    uart_tx_sched_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .DATA_W(DW), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .clk16  (clk16),
        .bus    (bus.slave)
    );

    initial forever #5 sysclk = ~sysclk;

    // clk16: period of 4 sysclk, frozen while stall is set
    initial forever begin
        @(posedge sysclk);
        #1;
        if (!stall) begin
            ph    = (ph + 1) % 4;
            clk16 = (ph >= 2);
        end
    end

    // Receiver counting clk16 rises; samples mid-bit so it is immune to stalls
    initial forever begin
        @(negedge sysclk);
        rx_rise  = clk16 && !c16_prev;
        c16_prev = clk16;
        if (rst) begin
            rx_st = 0;
        end else if (rx_st == 0) begin
            if (bus.txd === 1'b0) begin
                rx_st = 1;
                rx_n  = 0;
            end
        end else if (rx_rise) begin
            rx_n++;
            if (rx_n == MIDB && bus.txd !== 1'b0) begin
                rx_st = 0;
            end else if (rx_n > MIDB && (rx_n - MIDB) % OS == 0) begin
                if (rx_n == MIDB + OS * (DW + 1)) begin
                    rx_q.push_back(rx_sh);
                    if (bus.txd !== 1'b1) rx_ferr++;
                    rx_st = 0;
                end else begin
                    rx_sh = {bus.txd, rx_sh[7:1]};
                end
            end
        end
    end

    function automatic int rr_next(int last, logic [NREQ-1:0] pend);
        for (int k = 1; k <= NREQ; k++)
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic step();
        @(negedge sysclk);
        if (bus.gnt !== '0) begin
            g_vec.push_back(bus.gnt);
            g_own.push_back(int'(bus.owner));
            if (auto_drop) bus.req = bus.req & ~bus.gnt;
        end
    endtask

    task automatic clear_logs();
        g_vec.delete();
        g_own.delete();
        rx0 = rx_q.size();
        fe0 = rx_ferr;
    endtask

    task automatic set_data(int i, logic [7:0] v);
        bus.data[i*DW +: DW] = v;
    endtask

    task automatic wait_gnt(int n, int limit, output bit to);
        to = 1'b0;
        for (int c = 0; g_vec.size() < n; c++) begin
            if (c >= limit) begin to = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_done(int n, int limit, output bit to);
        to = 1'b0;
        for (int c = 0; !((rx_q.size() - rx0) >= n && bus.busy === 1'b0); c++) begin
            if (c >= limit) begin to = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        chk_cnt++; if (bus.txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", bus.txd); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.gnt !== '0) $display("FAIL reset_gnt: got %b want 0", bus.gnt); else pass_cnt++;
        chk_cnt++; if (bus.owner !== '0) $display("FAIL reset_owner: got %0d want 0", bus.owner); else pass_cnt++;
        rst = 1'b0;
        m_last = NREQ - 1;
        repeat (20) step();
        chk_cnt++; if (bus.txd !== 1'b1 || bus.busy !== 1'b0) $display("FAIL idle_line: got txd=%b busy=%b want 1/0", bus.txd, bus.busy); else pass_cnt++;
        chk_cnt++; if (g_vec.size() != 0) $display("FAIL idle_nognt: got %0d grants want 0", g_vec.size()); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [9:0] fb;
        int er[$];
        int runs[$];
        int cur, len;
        logic lvl;
        bit to;
        clear_logs();
        fb = {1'b1, 8'h55, 1'b0};
        cur = 4 * OS;
        for (int i = 1; i < 10; i++) begin
            if (fb[i] == fb[i-1]) cur += 4 * OS;
            else begin er.push_back(cur); cur = 4 * OS; end
        end
        er.push_back(cur);
        // present the request just before a tick so the start bit is a full bit period
        for (int k = 0; k < 8 && ph != 2; k++) step();
        set_data(0, 8'h55);
        bus.req = 3'b001;
        auto_drop = 1'b1;
        step();
        chk_cnt++; if (bus.gnt !== 3'b001) $display("FAIL single_gnt: got %b want 001", bus.gnt); else pass_cnt++;
        chk_cnt++; if (bus.owner !== 2'd0) $display("FAIL single_owner: got %0d want 0", bus.owner); else pass_cnt++;
        chk_cnt++; if (bus.txd !== 1'b0 || bus.busy !== 1'b1) $display("FAIL single_start: got txd=%b busy=%b want 0/1", bus.txd, bus.busy); else pass_cnt++;
        m_last = 0;
        lvl = 1'b0;
        len = 1;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (k == 0) begin
                chk_cnt++; if (bus.gnt !== '0) $display("FAIL single_gnt_pulse: got %b want 000", bus.gnt); else pass_cnt++;
            end
            if (bus.busy !== 1'b1) break;
            if (bus.txd === lvl) len++;
            else begin runs.push_back(len); lvl = bus.txd; len = 1; end
        end
        runs.push_back(len);
        chk_cnt++; if (runs.size() != er.size()) $display("FAIL single_levels: got %0d want %0d", runs.size(), er.size()); else pass_cnt++;
        for (int i = 0; i < er.size() && i < runs.size(); i++) begin
            chk_cnt++; if (runs[i] != er[i]) $display("FAIL single_len%0d: got %0d want %0d", i, runs[i], er[i]); else pass_cnt++;
        end
        wait_done(1, 200, to);
        chk_cnt++; if (to || rx_q.size() - rx0 != 1) $display("FAIL single_rxcount: got %0d want 1", rx_q.size() - rx0); else pass_cnt++;
        chk_cnt++; if (!to && rx_q[rx0] !== 8'h55) $display("FAIL single_byte: got %h want 55", rx_q[rx0]); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [7:0] bytes[NREQ];
        int order[$];
        logic [NREQ-1:0] oh;
        bit to;
        @(negedge sysclk);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        m_last = NREQ - 1;
        clear_logs();
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h00;
        for (int i = 0; i < NREQ; i++) set_data(i, bytes[i]);
        for (int k = 0; k < 4; k++) begin
            order.push_back(rr_next(m_last, 3'b011));
            m_last = order[k];
        end
        auto_drop = 1'b0;
        bus.req = 3'b011;
        wait_gnt(4, 4000, to);
        bus.req = '0;
        auto_drop = 1'b1;
        chk_cnt++; if (to) $display("FAIL contention_gnt_timeout: got %0d grants want 4", g_vec.size()); else pass_cnt++;
        wait_done(4, 2000, to);
        chk_cnt++; if (to || g_vec.size() != 4) $display("FAIL contention_count: got %0d grants want 4", g_vec.size()); else pass_cnt++;
        for (int k = 0; k < 4 && k < g_vec.size() && k < rx_q.size() - rx0; k++) begin
            oh = '0; oh[order[k]] = 1'b1;
            chk_cnt++; if (g_vec[k] !== oh) $display("FAIL contention_gnt%0d: got %b want %b", k, g_vec[k], oh); else pass_cnt++;
            chk_cnt++; if (g_own[k] != order[k]) $display("FAIL contention_owner%0d: got %0d want %0d", k, g_own[k], order[k]); else pass_cnt++;
            chk_cnt++; if (rx_q[rx0+k] !== bytes[order[k]]) $display("FAIL contention_byte%0d: got %h want %h", k, rx_q[rx0+k], bytes[order[k]]); else pass_cnt++;
        end
        chk_cnt++; if (rx_ferr != fe0) $display("FAIL contention_framing: got %0d errors want 0", rx_ferr - fe0); else pass_cnt++;
    endtask

    task automatic test_midreset();
        int exp;
        bit to;
        clear_logs();
        set_data(1, 8'h3C);
        bus.req = 3'b010;
        exp = rr_next(m_last, 3'b010);
        wait_gnt(1, 100, to);
        chk_cnt++; if (to || exp != 1 || g_vec[0] !== 3'b010) $display("FAIL midrst_first_gnt: got %b want 010", to ? 3'b000 : g_vec[0]); else pass_cnt++;
        for (int k = 0; k < 2000 && !(rx_st == 1 && rx_n >= MIDB + OS * 4); k++) step();
        chk_cnt++; if (!(rx_st == 1 && rx_n >= MIDB + OS * 4)) $display("FAIL midrst_reach_bit3: got rx_n=%0d want %0d", rx_n, MIDB + OS * 4); else pass_cnt++;
        rst = 1'b1;
        bus.req = 3'b011;
        set_data(0, 8'h81);
        #1;
        chk_cnt++; if (bus.txd !== 1'b1) $display("FAIL midrst_txd: got %b want 1", bus.txd); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.gnt !== '0 || bus.owner !== '0) $display("FAIL midrst_gnt_owner: got %b/%0d want 000/0", bus.gnt, bus.owner); else pass_cnt++;
        repeat (3) step();
        clear_logs();
        m_last = NREQ - 1;
        exp = rr_next(m_last, 3'b011);
        rst = 1'b0;
        wait_gnt(1, 100, to);
        bus.req = '0;
        chk_cnt++; if (to || g_vec[0] !== 3'b001 || exp != 0) $display("FAIL midrst_regrant: got %b want 001", to ? 3'b000 : g_vec[0]); else pass_cnt++;
        m_last = 0;
        wait_done(1, 1000, to);
        repeat (50) step();
        chk_cnt++; if (to || rx_q.size() - rx0 != 1) $display("FAIL midrst_frames: got %0d want 1", rx_q.size() - rx0); else pass_cnt++;
        chk_cnt++; if (!to && rx_q[rx0] !== 8'h81) $display("FAIL midrst_byte: got %h want 81", rx_q[rx0]); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [7:0] b;
        logic t0, b0;
        int changes;
        bit to;
        clear_logs();
        b = 8'($urandom);
        set_data(2, b);
        bus.req = 3'b100;
        m_last = rr_next(m_last, 3'b100);
        for (int k = 0; k < 2000 && !(rx_st == 1 && rx_n >= MIDB + OS * 3); k++) step();
        for (int k = 0; k < 8 && clk16 !== 1'b0; k++) step();
        stall = 1'b1;
        t0 = bus.txd;
        b0 = bus.busy;
        changes = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (bus.txd !== t0 || bus.busy !== b0) changes++;
        end
        chk_cnt++; if (changes != 0) $display("FAIL stall_hold: got %0d changes want 0", changes); else pass_cnt++;
        chk_cnt++; if (b0 !== 1'b1) $display("FAIL stall_busy: got %b want 1", b0); else pass_cnt++;
        stall = 1'b0;
        wait_done(1, 1000, to);
        chk_cnt++; if (to || g_vec.size() != 1 || g_vec[0] !== 3'b100) $display("FAIL stall_gnt: got %0d grants want one of 100", g_vec.size()); else pass_cnt++;
        chk_cnt++; if (to || rx_q[rx0] !== b || rx_ferr != fe0) $display("FAIL stall_byte: got %h want %h", to ? 8'h00 : rx_q[rx0], b); else pass_cnt++;
    endtask

    task automatic test_withdraw();
        logic [7:0] b;
        int lows;
        bit to;
        clear_logs();
        b = 8'($urandom);
        set_data(0, b);
        set_data(1, 8'hC3);
        bus.req = 3'b001;
        m_last = rr_next(m_last, 3'b001);
        wait_gnt(1, 100, to);
        repeat (100) step();
        bus.req = 3'b010;
        step();
        bus.req = '0;
        wait_done(1, 1000, to);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (bus.txd !== 1'b1) lows++;
        end
        chk_cnt++; if (to || g_vec.size() != 1 || g_vec[0] !== 3'b001) $display("FAIL withdraw_gnt: got %0d grants want one of 001", g_vec.size()); else pass_cnt++;
        chk_cnt++; if (lows != 0) $display("FAIL withdraw_txd_idle: got %0d low cycles want 0", lows); else pass_cnt++;
        chk_cnt++; if (rx_q.size() - rx0 != 1 || rx_q[rx0] !== b) $display("FAIL withdraw_byte: got %0d frames want 1 of %h", rx_q.size() - rx0, b); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] set, pend, oh;
        logic [7:0] bytes[NREQ];
        int order[$];
        bit to;
        for (int r = 0; r < 5; r++) begin
            clear_logs();
            order.delete();
            set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                bytes[i] = 8'($urandom);
                set_data(i, bytes[i]);
            end
            pend = set;
            while (pend != '0) begin
                m_last = rr_next(m_last, pend);
                order.push_back(m_last);
                pend[m_last] = 1'b0;
            end
            bus.req = set;
            wait_done(order.size(), 700 * order.size() + 200, to);
            chk_cnt++; if (to || g_vec.size() != order.size()) $display("FAIL random%0d_count: got %0d want %0d", r, g_vec.size(), order.size()); else pass_cnt++;
            for (int k = 0; k < order.size() && k < g_vec.size() && k < rx_q.size() - rx0; k++) begin
                oh = '0; oh[order[k]] = 1'b1;
                chk_cnt++; if (g_vec[k] !== oh || g_own[k] != order[k]) $display("FAIL random%0d_gnt%0d: got %b/%0d want %b/%0d", r, k, g_vec[k], g_own[k], oh, order[k]); else pass_cnt++;
                chk_cnt++; if (rx_q[rx0+k] !== bytes[order[k]]) $display("FAIL random%0d_byte%0d: got %h want %h", r, k, rx_q[rx0+k], bytes[order[k]]); else pass_cnt++;
            end
            chk_cnt++; if (rx_ferr != fe0) $display("FAIL random%0d_framing: got %0d errors want 0", r, rx_ferr - fe0); else pass_cnt++;
        end
    endtask

    initial begin
        bus.req  = '0;
        bus.data = '0;
        test_reset();
        test_single();
        test_contention();
        test_midreset();
        test_stall();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
